// File: rtl/rr_slot_arbiter_pkg.sv
// rr_arb_pkg: arbiter state enum, hold counter width, one-hot index and ring-rotate helpers
package rr_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int HOLD_W = 8;
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r = v[i] ? r | 5'(i) : r;
    return r;
  endfunction
  function automatic logic [31:0] rotl1(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (i < n && v[i]) r[(i + 1) % n] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/rr_slot_arbiter_pick.sv
// rr_pick: combinational round-robin select; req/ptr in, one-hot pick and any out, first req at or above ptr wins with wrap
module rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick,
  output logic         any
);
  logic [N-1:0] masked;
  always_comb begin
    masked = req & ~(ptr - N'(1));
    pick = |masked ? masked & (~masked + N'(1)) : req & (~req + N'(1));
    any = |req;
  end
endmodule

// File: rtl/rr_slot_arbiter.sv
// rr_slot_arbiter: round-robin slot arbiter with max-hold preemption; clk/rst, req in, registered gnt/gnt_valid/gnt_id/preempt out
module rr_slot_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int MAX_HOLD = 16,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           preempt
);
  state_t state;
  logic [N-1:0] ptr, pick;
  logic any, owner_req, rel;
  logic [HOLD_W-1:0] hold_cnt;
  rr_pick #(.N(N)) u_pick (.req(req), .ptr(ptr), .pick(pick), .any(any));
  always_comb begin
    owner_req = |(req & gnt);
    rel = !owner_req || hold_cnt == HOLD_W'(MAX_HOLD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      gnt_valid <= 1'b0;
      gnt_id <= '0;
      preempt <= 1'b0;
      ptr <= N'(1);
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      preempt <= 1'b0;
      if (any) begin
        state <= GRANT;
        gnt <= pick;
        gnt_valid <= 1'b1;
        gnt_id <= IDW'(onehot_to_idx(32'(pick)));
        hold_cnt <= HOLD_W'(1);
      end
    end else if (rel) begin
      state <= IDLE;
      gnt <= '0;
      gnt_valid <= 1'b0;
      gnt_id <= '0;
      preempt <= owner_req;
      ptr <= N'(rotl1(32'(gnt), N));
      hold_cnt <= '0;
    end else begin
      preempt <= 1'b0;
      hold_cnt <= &hold_cnt ? hold_cnt : hold_cnt + HOLD_W'(1);
    end
  end
endmodule

// File: tb/tb_rr_slot_arbiter.sv
// tb_rr_slot_arbiter: directed plan plus randomized traffic checked against an index-level round-robin model
module tb_rr_slot_arbiter;
  localparam int N = 8;
  localparam int MAXH = 4;
  logic clk = 0, rst = 1;
  logic [N-1:0] req = '1;
  logic [N-1:0] gnt;
  logic gnt_valid, preempt;
  logic [2:0] gnt_id;
  int total = 0, bad = 0;
  int own = -1, pidx = 0, cnt = 0;
  bit pre = 0, armed = 0;
  rr_slot_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .preempt(preempt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  // reference: owner index, hold count and pointer index advanced by the release/grant rules
  always @(posedge clk) begin
    if (rst) begin
      own = -1; pidx = 0; cnt = 0; pre = 0; armed = 1;
    end else if (own < 0) begin
      pre = 0;
      for (int j = 0; j < N; j++)
        if (own < 0 && req[(pidx + j) % N]) begin
          own = (pidx + j) % N;
          cnt = 1;
        end
    end else if (!req[own] || cnt == MAXH) begin
      pre = req[own];
      pidx = (own + 1) % N;
      own = -1;
    end else begin
      cnt++;
      pre = 0;
    end
    #1;
    if (armed) begin
      chk("m_gnt", 32'(gnt), own < 0 ? 0 : 32'(1) << own);
      chk("m_valid", 32'(gnt_valid), own < 0 ? 0 : 1);
      chk("m_id", 32'(gnt_id), own < 0 ? 0 : own);
      chk("m_pre", 32'(preempt), 32'(pre));
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  initial begin
    tick();
    chk("rst_gnt0", 32'(gnt), 0);
    chk("rst_pre0", 32'(preempt), 0);
    tick();
    chk("rst_gnt1", 32'(gnt), 0);
    chk("rst_valid", 32'(gnt_valid), 0);
    chk("rst_id", 32'(gnt_id), 0);
    rst = 0;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("rot_gnt", 32'(gnt), 32'(1) << (g % 8));
        chk("rot_id", 32'(gnt_id), g % 8);
        if (c == 3) c = 3;
      end
      tick();
      chk("rot_gap", 32'(gnt), 0);
      chk("rot_pre", 32'(preempt), 1);
    end
    req = 8'h08;
    tick();
    chk("t2_gnt_a", 32'(gnt), 8'h08);
    chk("t2_id", 32'(gnt_id), 3);
    tick();
    chk("t2_gnt_b", 32'(gnt), 8'h08);
    req = 8'h00;
    tick();
    chk("t2_rel", 32'(gnt), 0);
    chk("t2_pre", 32'(preempt), 0);
    req = 8'h40;
    tick();
    chk("t4_g6", 32'(gnt), 8'h40);
    req = 8'h00;
    tick();
    chk("t4_rel6", 32'(gnt), 0);
    req = 8'h81;
    tick();
    chk("t4_g7", 32'(gnt), 8'h80);
    chk("t4_id7", 32'(gnt_id), 7);
    repeat (3) tick();
    chk("t4_g7_last", 32'(gnt), 8'h80);
    tick();
    chk("t4_gap", 32'(gnt), 0);
    chk("t4_pre", 32'(preempt), 1);
    tick();
    chk("t4_wrap", 32'(gnt), 8'h01);
    req = 8'h00;
    tick();
    chk("t4_rel0", 32'(gnt), 0);
    req = 8'h20;
    tick();
    tick();
    chk("t5_held", 32'(gnt), 8'h20);
    rst = 1;
    tick();
    chk("t5_rst", 32'(gnt), 0);
    chk("t5_rst_pre", 32'(preempt), 0);
    rst = 0;
    tick();
    chk("t5_regnt", 32'(gnt), 8'h20);
    chk("t5_id", 32'(gnt_id), 5);
    req = 8'h00;
    tick();
    req = 8'h04;
    tick();
    chk("t6_g2", 32'(gnt), 8'h04);
    repeat (3) tick();
    chk("t6_g2_last", 32'(gnt), 8'h04);
    req = 8'h00;
    tick();
    chk("t6_rel", 32'(gnt), 0);
    chk("t6_pre", 32'(preempt), 0);
    req = 8'h04;
    tick();
    chk("t6_regnt", 32'(gnt), 8'h04);
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(3))
        0: req = 8'($urandom);
        1: req = 8'($urandom) & 8'($urandom);
        2: req = 8'(32'(1) << $urandom_range(7));
        default: req = $urandom_range(3) == 0 ? 8'h00 : req;
      endcase
      rst = $urandom_range(199) == 0;
      tick();
    end
    rst = 0;
    req = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
